issue_scheduler: RTL

- Selects up to `N` ready reservation-station entries per cycle for issue.
- Enforces per-class functional-unit port limits and a CDB writeback-slot budget, so no future cycle sees more than `N` completions.
- Uses a rotating priority pointer for fairness. It sits between the RS (ready bits, FU class per entry) and the issue/execute registers, and drives the RS `rs_data_issuing` vector.

---
 rtl/issue_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/issue_scheduler.sv
// ---------------------------------------------------------------------------
// issue_scheduler
//
// Picks up to N ready reservation-station entries per cycle for issue. The
// scan starts at a rotating priority pointer and wraps around the RS. A
// ready entry is granted only if all of the following have room:
//   - the issue width (N per cycle),
//   - the ports of its functional-unit class,
//   - the common data bus (CDB) slots in the cycle it will complete.
// A skipped entry never blocks the entries scanned after it.
//
// CDB bookkeeping:
//   ALU, BR and MEM operations complete one cycle after issue.
//   Multiplies complete MULT_LAT cycles after issue.
//   cdb_resv holds the multiply completions already booked for each future
//   cycle, so no cycle ever retires more than N results.
//
// Ports
//   clock            system clock
//   reset            asynchronous, active-high; clears pointer and
//                    reservations and forces the grant outputs to zero
//   rs_ready         per entry: valid and both sources ready
//   rs_fu_type       per entry FU class: 0=ALU 1=MULT 2=BR 3=MEM
//   issue_stall      execute stage cannot accept; grant nothing
//   mem_busy         load/store unit busy; no MEM grant
//   rs_data_issuing  one bit per entry granted this cycle
//   num_issued       popcount of rs_data_issuing
//   prio_ptr         entry scanned first this cycle (debug)
//   cdb_resv         element [k-1] = CDB slots reserved k cycles ahead,
//                    k = 1..MULT_LAT (debug)
//
// MULT_LAT must be at least 2.
// ---------------------------------------------------------------------------
module issue_scheduler #(
    parameter int RS_SZ    = 16,
    parameter int N        = 2,
    parameter int NUM_ALU  = 2,
    parameter int NUM_MULT = 1,
    parameter int NUM_BR   = 1,
    parameter int NUM_MEM  = 1,
    parameter int MULT_LAT = 4
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [RS_SZ-1:0]                        rs_ready,
    input  logic [RS_SZ-1:0][1:0]                   rs_fu_type,
    input  logic                                    issue_stall,
    input  logic                                    mem_busy,
    output logic [RS_SZ-1:0]                        rs_data_issuing,
    output logic [$clog2(N+1)-1:0]                  num_issued,
    output logic [$clog2(RS_SZ)-1:0]                prio_ptr,
    output logic [MULT_LAT-1:0][$clog2(N+1)-1:0]    cdb_resv
);

    localparam int CW = $clog2(N+1);
    localparam int PW = $clog2(RS_SZ);

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_BR   = 2'd2,
        FU_MEM  = 2'd3
    } fu_e;

    // Running grant counts, in scan order.
    int n_tot;    // all grants
    int n_alu;    // ALU grants
    int n_mult;   // multiply grants
    int n_br;     // branch grants
    int n_mem;    // load/store grants
    int n_off1;   // grants completing next cycle (everything but MULT)

    logic [RS_SZ-1:0]  grant;
    logic [PW-1:0]     scan_idx;
    logic [PW-1:0]     last_idx;
    fu_e               cls;
    logic              room_off1;
    logic              room_mult;
    logic              grant_ok;

    logic [MULT_LAT-1:0][CW-1:0] resv_nxt;

    // -----------------------------------------------------------------
    // Combinational grant selection
    //
    // The loop walks the RS once, starting at prio_ptr. RS_SZ is a power
    // of two, so the PW-bit add wraps the index for free. Reset and stall
    // both gate the whole scan: no grant, so no counter moves.
    // -----------------------------------------------------------------
    always_comb begin
        grant     = '0;
        n_tot     = 0;
        n_alu     = 0;
        n_mult    = 0;
        n_br      = 0;
        n_mem     = 0;
        n_off1    = 0;
        scan_idx  = '0;
        last_idx  = prio_ptr;
        cls       = FU_ALU;
        room_off1 = 1'b0;
        room_mult = 1'b0;
        grant_ok  = 1'b0;

        if (!reset && !issue_stall) begin
            for (int i = 0; i < RS_SZ; i++) begin
                scan_idx = prio_ptr + PW'(i);
                cls      = fu_e'(rs_fu_type[scan_idx]);

                // Single-cycle ops share next cycle's CDB slots with the
                // multiplies that were booked for that cycle earlier.
                room_off1 = (int'(cdb_resv[0]) + n_off1) < N;

                // A multiply lands MULT_LAT cycles out.
                room_mult = (int'(cdb_resv[MULT_LAT-1]) + n_mult) < N;

                case (cls)
                    FU_ALU:  grant_ok = (n_alu  < NUM_ALU)  && room_off1;
                    FU_MULT: grant_ok = (n_mult < NUM_MULT) && room_mult;
                    FU_BR:   grant_ok = (n_br   < NUM_BR)   && room_off1;
                    FU_MEM:  grant_ok = (n_mem  < NUM_MEM)  && room_off1
                                        && !mem_busy;
                    default: grant_ok = 1'b0;
                endcase

                grant_ok = grant_ok && rs_ready[scan_idx] && (n_tot < N);

                if (grant_ok) begin
                    grant[scan_idx] = 1'b1;
                    n_tot           = n_tot + 1;
                    last_idx        = scan_idx;
                    case (cls)
                        FU_ALU:  n_alu  = n_alu  + 1;
                        FU_MULT: n_mult = n_mult + 1;
                        FU_BR:   n_br   = n_br   + 1;
                        FU_MEM:  n_mem  = n_mem  + 1;
                        default: ;
                    endcase
                    if (cls != FU_MULT) begin
                        n_off1 = n_off1 + 1;
                    end
                end
            end
        end
    end

    assign rs_data_issuing = grant;
    assign num_issued      = CW'(n_tot);

    // -----------------------------------------------------------------
    // Next reservation window
    //
    // The window shifts one step toward "now" every cycle, even on a
    // stall, because multiplies already in flight still complete.
    //
    // This cycle's single-cycle grants used the old offset-1 slot, which
    // is retired by the shift, so they are never stored.
    //
    // A multiply granted now completes MULT_LAT cycles ahead. After the
    // shift that is MULT_LAT-1 cycles ahead, which is element
    // [MULT_LAT-2] of the window.
    // -----------------------------------------------------------------
    always_comb begin
        resv_nxt = '0;
        for (int k = 0; k < MULT_LAT - 1; k++) begin
            resv_nxt[k] = cdb_resv[k+1];
        end
        resv_nxt[MULT_LAT-2] = cdb_resv[MULT_LAT-1] + CW'(n_mult);
    end

    // -----------------------------------------------------------------
    // State registers
    //
    // The pointer moves to one past the last grant made in scan order.
    // With no grant it holds, so an idle or stalled cycle costs no
    // fairness.
    // -----------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_ptr <= '0;
            cdb_resv <= '0;
        end else begin
            cdb_resv <= resv_nxt;
            if (n_tot != 0) begin
                prio_ptr <= last_idx + PW'(1);
            end
        end
    end

endmodule
